// File: rtl/stack_ctrl.sv
// stack_ctrl: return-address stack sequencer.
// Drives an external single-port synchronous RAM for call/return.
// Tracks the stack pointer and stalls fetch while a pop read is in flight.
module stack_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] pc_ret,
    input  logic          err_clr,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          stall,
    output logic          ret_valid,
    output logic [DW-1:0] ret_addr,
    output logic [AW:0]   sp,
    output logic          full,
    output logic          empty,
    output logic          err_ovf,
    output logic          err_udf
);

    typedef enum logic [1:0] {IDLE, RD, RET} state_t;

    localparam logic [AW:0] SP_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_ONE = (AW+1)'(1);

    state_t        state_reg, state_next;
    logic [AW:0]   sp_reg, sp_next;
    logic [DW-1:0] ret_addr_reg, ret_addr_next;
    logic          err_ovf_reg, err_ovf_next;
    logic          err_udf_reg, err_udf_next;
    logic          ovf_set, udf_set;
    logic          push_only, pop_only;
    logic [AW:0]   sp_m1;

    assign push_only = push & ~pop;
    assign pop_only  = pop & ~push;
    assign sp_m1     = sp_reg - SP_ONE;
    assign full      = (sp_reg == SP_MAX);
    assign empty     = (sp_reg == '0);

    // Next-state, RAM control and handshake decode.
    // After an accepted pop sp already points at the popped slot, so RD/RET
    // address the RAM with sp directly.
    always_comb begin
        state_next    = state_reg;
        sp_next       = sp_reg;
        ret_addr_next = ret_addr_reg;
        ram_we        = 1'b0;
        ram_addr      = sp_m1[AW-1:0];
        stall         = 1'b0;
        ret_valid     = 1'b0;
        ovf_set       = 1'b0;
        udf_set       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (push_only) begin
                    ram_addr = sp_reg[AW-1:0];
                    if (!full) begin
                        ram_we  = 1'b1;
                        sp_next = sp_reg + SP_ONE;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (pop_only) begin
                    if (!empty) begin
                        stall      = 1'b1;
                        sp_next    = sp_m1;
                        state_next = RD;
                    end else begin
                        udf_set = 1'b1;
                    end
                end
            end
            RD: begin
                stall         = 1'b1;
                ram_addr      = sp_reg[AW-1:0];
                ret_addr_next = ram_rdata;
                state_next    = RET;
            end
            RET: begin
                ret_valid  = 1'b1;
                ram_addr   = sp_reg[AW-1:0];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A new error in the same cycle as err_clr keeps the flag set.
        err_ovf_next = ovf_set | (err_ovf_reg & ~err_clr);
        err_udf_next = udf_set | (err_udf_reg & ~err_clr);
    end

    // State, stack pointer, return address and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            sp_reg       <= '0;
            ret_addr_reg <= '0;
            err_ovf_reg  <= 1'b0;
            err_udf_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sp_reg       <= sp_next;
            ret_addr_reg <= ret_addr_next;
            err_ovf_reg  <= err_ovf_next;
            err_udf_reg  <= err_udf_next;
        end
    end

    assign ram_wdata = pc_ret;
    assign ret_addr  = ret_addr_reg;
    assign sp        = sp_reg;
    assign err_ovf   = err_ovf_reg;
    assign err_udf   = err_udf_reg;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed plus randomized check of stack_ctrl against a
// queue-based stack model and a behavioural stack RAM.
module tb_stack_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 10;

    logic          clk = 1'b0;
    logic          reset, push, pop, err_clr;
    logic [DW-1:0] pc_ret;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          stall, ret_valid, full, empty, err_ovf, err_udf;
    logic [DW-1:0] ret_addr;
    logic [AW:0]   sp;

    int checks = 0;
    int errors = 0;

    stack_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .pc_ret(pc_ret),
        .err_clr(err_clr), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .stall(stall),
        .ret_valid(ret_valid), .ret_addr(ret_addr), .sp(sp), .full(full),
        .empty(empty), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    // Stack RAM: synchronous write, registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stack is a queue; phase 0 = accepting commands,
    // 1 = read in flight, 2 = returning.
    logic [DW-1:0] m_q[$];
    int            m_phase = 0;
    logic [DW-1:0] m_pend, m_ret;
    logic          m_ovf, m_udf;
    bit            started = 0;

    always @(posedge clk) begin
        bit ovf_s, udf_s;
        ovf_s = 0;
        udf_s = 0;
        if (reset) begin
            m_q.delete();
            m_phase = 0;
            m_ret   = '0;
            m_ovf   = 0;
            m_udf   = 0;
            started = 1;
        end else if (started) begin
            case (m_phase)
                0: begin
                    if (push && !pop) begin
                        if (m_q.size() < DEPTH) m_q.push_back(pc_ret);
                        else ovf_s = 1;
                    end else if (pop && !push) begin
                        if (m_q.size() > 0) begin
                            m_pend  = m_q.pop_back();
                            m_phase = 1;
                        end else udf_s = 1;
                    end
                end
                1: begin
                    m_ret   = m_pend;
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
            m_ovf = ovf_s | (m_ovf & ~err_clr);
            m_udf = udf_s | (m_udf & ~err_clr);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            int  n;
            bit  p_only, q_only;
            n      = m_q.size();
            p_only = push && !pop;
            q_only = pop && !push;
            chk("sp", 32'(sp), 32'(n));
            chk("full", 32'(full), 32'(n == DEPTH));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
            chk("err_udf", 32'(err_udf), 32'(m_udf));
            chk("ret_addr", 32'(ret_addr), 32'(m_ret));
            chk("ram_wdata", 32'(ram_wdata), 32'(pc_ret));
            chk("ret_valid", 32'(ret_valid), 32'(m_phase == 2));
            if (m_phase == 0) begin
                chk("ram_we", 32'(ram_we), 32'(p_only && n < DEPTH));
                chk("stall", 32'(stall), 32'(q_only && n > 0));
                if (p_only && n < DEPTH) chk("ram_addr_push", 32'(ram_addr), 32'(n));
                if (q_only && n > 0)     chk("ram_addr_pop", 32'(ram_addr), 32'(n - 1));
            end else begin
                chk("ram_we", 32'(ram_we), 32'(0));
                chk("stall", 32'(stall), 32'(m_phase == 1));
                chk("ram_addr_hold", 32'(ram_addr), 32'(n));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_v(input logic [DW-1:0] v);
        push = 1; pc_ret = v; tick(); push = 0;
    endtask

    task automatic pop_expect(input logic [DW-1:0] v);
        pop = 1; tick(); pop = 0;   // now in RD
        tick();                     // now in RET
        chk("lit_ret_valid", 32'(ret_valid), 32'(1));
        chk("lit_ret_addr", 32'(ret_addr), 32'(v));
        tick();
    endtask

    initial begin
        reset = 1; push = 0; pop = 0; err_clr = 0; pc_ret = '0;
        repeat (2) tick();
        reset = 0;
        chk("lit_reset_sp", 32'(sp), 32'(0));

        push_v(10'h005); push_v(10'h00A); push_v(10'h00F);
        chk("lit_sp3", 32'(sp), 32'(3));
        pop_expect(10'h00F); pop_expect(10'h00A); pop_expect(10'h005);
        chk("lit_empty", 32'(empty), 32'(1));

        pop = 1; tick(); pop = 0;
        chk("lit_udf", 32'(err_udf), 32'(1));
        chk("lit_udf_sp", 32'(sp), 32'(0));
        err_clr = 1; tick(); err_clr = 0;
        chk("lit_udf_clr", 32'(err_udf), 32'(0));

        for (int i = 0; i < DEPTH; i++) push_v(10'(10'h100 + i));
        chk("lit_full", 32'(full), 32'(1));
        push_v(10'h3FF);
        chk("lit_ovf", 32'(err_ovf), 32'(1));
        chk("lit_ovf_sp", 32'(sp), 32'(16));
        pop_expect(10'h10F);
        err_clr = 1; tick(); err_clr = 0;

        push = 1; pop = 1; pc_ret = 10'h2AA; tick(); push = 0; pop = 0;
        chk("lit_both_sp", 32'(sp), 32'(15));
        chk("lit_both_ovf", 32'(err_ovf), 32'(0));

        pop = 1; tick(); pop = 0;   // in RD
        reset = 1; tick(); reset = 0;
        chk("lit_rst_stall", 32'(stall), 32'(0));
        chk("lit_rst_valid", 32'(ret_valid), 32'(0));
        chk("lit_rst_sp", 32'(sp), 32'(0));
        repeat (3) tick();

        for (int c = 0; c < 4000; c++) begin
            int r;
            r       = int'($urandom_range(0, 99));
            push    = (r < 45) || (r >= 95);
            pop     = (r >= 45 && r < 80) || (r >= 95);
            err_clr = ($urandom_range(0, 19) == 0);
            pc_ret  = DW'($urandom);
            reset   = ($urandom_range(0, 299) == 0);
            tick();
        end
        push = 0; pop = 0; err_clr = 0; reset = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
